// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: DEPTH stages of {valid, ctrl, data}.
// Supports stall, flush (bubble into stage 0), kill (clear all) and counts bubbles.
module pipe_stage_reg #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 111,
    parameter int DEPTH      = 1,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         kill_i,
    input  logic                         valid_d,
    input  logic [CTRL_W-1:0]            ctrl_d,
    input  logic [DATA_W-1:0]            data_d,
    output logic                         valid_e,
    output logic [CTRL_W-1:0]            ctrl_e,
    output logic [DATA_W-1:0]            data_e,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o,
    output logic [CNT_W-1:0]             bubble_cnt_o
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  vld;
    logic [CTRL_W-1:0] ctl [DEPTH];
    logic [DATA_W-1:0] dat [DEPTH];
    logic [CNT_W-1:0]  bubble_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                vld[i] <= 1'b0;
                ctl[i] <= '0;
                dat[i] <= '0;
            end
            bubble_cnt <= '0;
        end else begin
            if (kill_i) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    vld[i] <= 1'b0;
                    ctl[i] <= '0;
                    if (CLEAR_DATA != 0) dat[i] <= '0;
                end
            end else begin
                // Flush overrides stall for stage 0 only; later stages follow stall.
                if (flush_i) begin
                    vld[0] <= 1'b0;
                    ctl[0] <= '0;
                    dat[0] <= (CLEAR_DATA != 0) ? '0 : data_d;
                end else if (!stall_i) begin
                    vld[0] <= valid_d;
                    ctl[0] <= valid_d ? ctrl_d : '0;
                    dat[0] <= data_d;
                end
                if (!stall_i) begin
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        vld[i] <= vld[i-1];
                        ctl[i] <= ctl[i-1];
                        dat[i] <= dat[i-1];
                    end
                end
            end
            if ((flush_i || kill_i) && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

    assign valid_e      = vld[DEPTH-1];
    assign ctrl_e       = ctl[DEPTH-1];
    assign data_e       = dat[DEPTH-1];
    assign occ_o        = OCC_W'($countones(vld));
    assign bubble_cnt_o = bubble_cnt;

endmodule
